bus_router_fifo: RTL and testbench

- Parametrised successor to the single-bus device interface: a central router between DRVRS devices on one bus.
- Pops packets from each device's pending queue, decodes the destination ID in the packet header, and delivers to per-device output FIFOs. Supports unicast and broadcast.
- Devices drain their output FIFOs through a pndng/pop handshake.
- Serves as the reference DUT core for the bus test environment.

---
 rtl/bus_router_pkg.sv | 40 ++++
 rtl/router_out_fifo.sv | 65 ++++++
 rtl/bus_router_fifo.sv | 124 ++++++++++++
 tb/tb_bus_router_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_router_pkg.sv
// Shared types and helpers for the bus router: header field width,
// broadcast ID, FSM states and destination decode.
package bus_router_pkg;

    localparam int ID_W        = 8;
    localparam int MAX_PCKG_SZ = 64;
    localparam int MAX_DRVRS   = 16;

    localparam logic [ID_W-1:0] BCAST_ID_DEF = 8'hFF;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } rtr_state_e;

    // Destination ID lives in the top ID_W bits of a sz-bit packet.
    function automatic logic [ID_W-1:0] pkt_dest(input logic [MAX_PCKG_SZ-1:0] pkt,
                                                 input int sz);
        return pkt[sz-1 -: ID_W];
    endfunction

    // One bit per destination FIFO. Invalid or self-addressed packets
    // yield an empty mask, which the router turns into a drop.
    function automatic logic [MAX_DRVRS-1:0] dest_mask(input logic [ID_W-1:0] dest,
                                                       input int src,
                                                       input int drvrs,
                                                       input logic [ID_W-1:0] bcast);
        logic [MAX_DRVRS-1:0] m;
        m = '0;
        if (dest == bcast) begin
            for (int j = 0; j < drvrs; j++) begin
                if (j != src) m[j] = 1'b1;
            end
        end else if (int'(dest) < drvrs && int'(dest) != src) begin
            m[dest[3:0]] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/router_out_fifo.sv
// Per-device output FIFO: synchronous, show-ahead, head reads as zero
// while empty so out_data is clean during and after reset.
module router_out_fifo #(
    parameter int PCKG_SZ = 16,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [PCKG_SZ-1:0] wr_data,
    input  logic               rd_en,
    output logic [PCKG_SZ-1:0] rd_data,
    output logic               empty,
    output logic               full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PCKG_SZ-1:0] mem_q [DEPTH];
    logic [PCKG_SZ-1:0] mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               wr_go, rd_go;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap naturally, DEPTH is 2^n) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_go    = wr_en && !full;
        rd_go    = rd_en && !empty;
        if (wr_go) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_go) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_go, rd_go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_router_fifo.sv
// Central router: round-robin pops one pending device packet, decodes its
// destination, and writes it into one (unicast) or all-but-source
// (broadcast) output FIFOs on the following cycle.
module bus_router_fifo
    import bus_router_pkg::*;
#(
    parameter int              PCKG_SZ  = 16,
    parameter int              DRVRS    = 4,
    parameter int              DEPTH    = 8,
    parameter logic [ID_W-1:0] BCAST_ID = BCAST_ID_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DRVRS-1:0]                in_pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   in_data,
    output logic [DRVRS-1:0]                in_pop,
    output logic [DRVRS-1:0]                out_pndng,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]   out_data,
    input  logic [DRVRS-1:0]                out_pop,
    output logic [15:0]                     drop_cnt
);
    localparam int PTR_W = $clog2(DRVRS);

    rtr_state_e                     state_q, state_d;
    logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [PCKG_SZ-1:0]             pkt_q, pkt_d;
    logic [DRVRS-1:0]               mask_q, mask_d;
    logic [15:0]                    drop_cnt_q, drop_cnt_d;

    logic [DRVRS-1:0][DRVRS-1:0]    src_mask;
    logic [DRVRS-1:0]               src_ok;
    logic [DRVRS-1:0]               grant;
    logic [DRVRS-1:0]               fifo_wr;
    logic [DRVRS-1:0]               fifo_full;
    logic [DRVRS-1:0]               fifo_empty;

    // Per-source decode and eligibility: every targeted FIFO must have room.
    // Empty masks (drops) are always eligible.
    always_comb begin
        src_mask = '0;
        src_ok   = '0;
        for (int s = 0; s < DRVRS; s++) begin
            src_mask[s] = DRVRS'(dest_mask(pkt_dest(MAX_PCKG_SZ'(in_data[s]), PCKG_SZ),
                                           s, DRVRS, BCAST_ID));
            src_ok[s]   = in_pndng[s] && ((src_mask[s] & fifo_full) == '0);
        end
    end

    // FSM next-state: IDLE grants the first eligible source from rr_ptr,
    // XFER commits the registered packet or counts a drop.
    always_comb begin
        int  idx;
        logic found;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        pkt_d      = pkt_q;
        mask_d     = mask_q;
        drop_cnt_d = drop_cnt_q;
        grant      = '0;
        fifo_wr    = '0;
        found      = 1'b0;
        idx        = 0;
        case (state_q)
            IDLE: begin
                for (int k = 0; k < DRVRS; k++) begin
                    idx = (int'(rr_ptr_q) + k) % DRVRS;
                    if (!found && src_ok[idx]) begin
                        found      = 1'b1;
                        grant[idx] = 1'b1;
                        pkt_d      = in_data[idx];
                        mask_d     = src_mask[idx];
                        rr_ptr_d   = PTR_W'((idx + 1) % DRVRS);
                        state_d    = XFER;
                    end
                end
            end
            XFER: begin
                fifo_wr = mask_q;
                if (mask_q == '0 && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset also discards any captured packet.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            pkt_q      <= '0;
            mask_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pkt_q      <= pkt_d;
            mask_q     <= mask_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Pop strobes are forced low while reset is held, even with pending input.
    assign in_pop    = grant & {DRVRS{reset}};
    assign out_pndng = ~fifo_empty;
    assign drop_cnt  = drop_cnt_q;

    for (genvar i = 0; i < DRVRS; i++) begin : g_fifo
        router_out_fifo #(
            .PCKG_SZ (PCKG_SZ),
            .DEPTH   (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (fifo_wr[i]),
            .wr_data (pkt_q),
            .rd_en   (out_pop[i]),
            .rd_data (out_data[i]),
            .empty   (fifo_empty[i]),
            .full    (fifo_full[i])
        );
    end

endmodule

// File: tb/tb_bus_router_fifo.sv
// Directed bench for bus_router_fifo with DRVRS=4, DEPTH=8, PCKG_SZ=16.
// A small device model feeds show-ahead queues and logs grants.
module tb_bus_router_fifo;

    logic              clk;
    logic              rst_n;
    logic [3:0]        in_pndng;
    logic [3:0][15:0]  in_data;
    logic [3:0]        in_pop;
    logic [3:0]        out_pndng;
    logic [3:0][15:0]  out_data;
    logic [3:0]        out_pop;
    logic [15:0]       drop_cnt;

    int vecs = 0;
    int errs = 0;

    logic [15:0] dmem [4][32];
    int          dhd  [4];
    int          dtl  [4];
    int          glog [$];
    logic [3:0]  pop_s;

    bus_router_fifo #(.PCKG_SZ(16), .DRVRS(4), .DEPTH(8), .BCAST_ID(8'hFF)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_pndng  (in_pndng),
        .in_data   (in_data),
        .in_pop    (in_pop),
        .out_pndng (out_pndng),
        .out_data  (out_data),
        .out_pop   (out_pop),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            in_pndng[i] = (dhd[i] != dtl[i]);
            in_data[i]  = in_pndng[i] ? dmem[i][dhd[i]] : 16'h0000;
        end
    endtask

    task automatic push(input int d, input logic [15:0] v);
        dmem[d][dtl[d]] = v;
        dtl[d]++;
        refresh();
    endtask

    task automatic clear_devs();
        for (int i = 0; i < 4; i++) begin
            dhd[i] = 0;
            dtl[i] = 0;
        end
        refresh();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Device side: consume the head on a pop strobe, log which device was granted.
    always @(posedge clk) begin
        pop_s = in_pop;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i]) begin
                glog.push_back(i);
                dhd[i]++;
            end
        end
        refresh();
    end

    task automatic test_reset();
        rst_n   = 1'b0;
        out_pop = '0;
        clear_devs();
        push(0, 16'h02A5);
        tick();
        vecs++; if (in_pop !== 4'b0000) begin $display("FAIL reset_in_pop got=%b exp=0000", in_pop); errs++; end
        vecs++; if (out_pndng !== 4'b0000) begin $display("FAIL reset_out_pndng got=%b exp=0000", out_pndng); errs++; end
        vecs++; if (out_data !== 64'h0) begin $display("FAIL reset_out_data got=%h exp=0", out_data); errs++; end
        vecs++; if (drop_cnt !== 16'h0) begin $display("FAIL reset_drop_cnt got=%h exp=0", drop_cnt); errs++; end
        clear_devs();
        rst_n = 1'b1;
        tick();
        glog.delete();
    endtask

    task automatic test_unicast();
        push(0, 16'h02A5);
        #1;
        vecs++; if (in_pop !== 4'b0001) begin $display("FAIL uni_pop got=%b exp=0001", in_pop); errs++; end
        tick();
        vecs++; if (in_pop !== 4'b0000) begin $display("FAIL uni_pop_once got=%b exp=0000", in_pop); errs++; end
        vecs++; if (out_pndng !== 4'b0000) begin $display("FAIL uni_early got=%b exp=0000", out_pndng); errs++; end
        tick();
        vecs++; if (out_pndng !== 4'b0100) begin $display("FAIL uni_pndng got=%b exp=0100", out_pndng); errs++; end
        vecs++; if (out_data[2] !== 16'h02A5) begin $display("FAIL uni_data got=%h exp=02a5", out_data[2]); errs++; end
        out_pop = 4'b0100;
        tick();
        out_pop = 4'b0000;
        vecs++; if (out_pndng !== 4'b0000) begin $display("FAIL uni_drain got=%b exp=0000", out_pndng); errs++; end
        vecs++; if (glog.size() != 1 || glog[0] != 0) begin $display("FAIL uni_grants got=%0d exp=1", glog.size()); errs++; end
        glog.delete();
    endtask

    task automatic test_broadcast();
        push(1, 16'hFF3C);
        tick(); tick(); tick();
        vecs++; if (out_pndng !== 4'b1101) begin $display("FAIL bc_pndng got=%b exp=1101", out_pndng); errs++; end
        vecs++; if (out_data[0] !== 16'hFF3C || out_data[2] !== 16'hFF3C || out_data[3] !== 16'hFF3C)
            begin $display("FAIL bc_data got=%h exp=ff3c,0,ff3c,ff3c", out_data); errs++; end
        vecs++; if (out_data[1] !== 16'h0) begin $display("FAIL bc_src got=%h exp=0", out_data[1]); errs++; end
        vecs++; if (drop_cnt !== 16'h0) begin $display("FAIL bc_drop got=%h exp=0", drop_cnt); errs++; end
        out_pop = 4'b1101;
        tick();
        out_pop = 4'b0000;
        vecs++; if (out_pndng !== 4'b0000) begin $display("FAIL bc_drain got=%b exp=0000", out_pndng); errs++; end
        glog.delete();
    endtask

    task automatic test_invalid();
        push(3, 16'h0711);
        push(3, 16'h0322);
        repeat (5) tick();
        vecs++; if (drop_cnt !== 16'd2) begin $display("FAIL inv_drop got=%0d exp=2", drop_cnt); errs++; end
        vecs++; if (out_pndng !== 4'b0000) begin $display("FAIL inv_pndng got=%b exp=0000", out_pndng); errs++; end
        vecs++; if (glog.size() != 2 || in_pndng[3] !== 1'b0) begin $display("FAIL inv_pops got=%0d exp=2", glog.size()); errs++; end
        glog.delete();
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 8; k++) push(3, 16'h0200 + 16'(k));
        repeat (18) tick();
        vecs++; if (out_pndng !== 4'b0100) begin $display("FAIL bp_fill got=%b exp=0100", out_pndng); errs++; end
        push(0, 16'h0299);
        push(1, 16'h0077);
        #1;
        vecs++; if (in_pop !== 4'b0010) begin $display("FAIL bp_skip got=%b exp=0010", in_pop); errs++; end
        for (int k = 0; k < 3; k++) begin
            tick();
            vecs++; if (in_pop !== 4'b0000) begin $display("FAIL bp_hold%0d got=%b exp=0000", k, in_pop); errs++; end
        end
        vecs++; if (out_pndng !== 4'b0101 || out_data[0] !== 16'h0077)
            begin $display("FAIL bp_d1 got=%b/%h exp=0101/0077", out_pndng, out_data[0]); errs++; end
        vecs++; if (out_data[2] !== 16'h0200) begin $display("FAIL bp_head got=%h exp=0200", out_data[2]); errs++; end
        out_pop = 4'b0100;
        tick();
        out_pop = 4'b0000;
        #1;
        vecs++; if (in_pop !== 4'b0001) begin $display("FAIL bp_release got=%b exp=0001", in_pop); errs++; end
        for (int k = 1; k < 8; k++) begin
            vecs++; if (out_data[2] !== 16'h0200 + 16'(k))
                begin $display("FAIL bp_order%0d got=%h exp=%h", k, out_data[2], 16'h0200 + 16'(k)); errs++; end
            out_pop = 4'b0100;
            tick();
            out_pop = 4'b0000;
        end
        vecs++; if (out_data[2] !== 16'h0299) begin $display("FAIL bp_tail got=%h exp=0299", out_data[2]); errs++; end
        out_pop = 4'b0101;
        tick();
        out_pop = 4'b0000;
        vecs++; if (out_pndng !== 4'b0000) begin $display("FAIL bp_drain got=%b exp=0000", out_pndng); errs++; end
        vecs++; if (drop_cnt !== 16'd2) begin $display("FAIL bp_drop got=%0d exp=2", drop_cnt); errs++; end
        glog.delete();
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        clear_devs();
        tick();
        rst_n = 1'b1;
        tick();
        glog.delete();
        push(0, 16'h0101); push(0, 16'h0102);
        push(1, 16'h0211); push(1, 16'h0212);
        push(2, 16'h0321); push(2, 16'h0322);
        push(3, 16'h0031); push(3, 16'h0032);
        repeat (20) tick();
        vecs++; if (glog.size() != 8) begin $display("FAIL rr_count got=%0d exp=8", glog.size()); errs++; end
        for (int k = 0; k < 5; k++) begin
            vecs++; if (glog.size() <= k || glog[k] != (k % 4))
                begin $display("FAIL rr_order%0d got=%0d exp=%0d", k, (glog.size() > k) ? glog[k] : -1, k % 4); errs++; end
        end
        vecs++; if (out_pndng !== 4'b1111) begin $display("FAIL rr_pndng got=%b exp=1111", out_pndng); errs++; end
        vecs++; if (out_data[1] !== 16'h0101 || out_data[0] !== 16'h0031)
            begin $display("FAIL rr_data got=%h/%h exp=0101/0031", out_data[1], out_data[0]); errs++; end
        glog.delete();
    endtask

    task automatic test_async_reset();
        push(2, 16'h0911);
        repeat (4) tick();
        vecs++; if (drop_cnt !== 16'd1) begin $display("FAIL ar_predrop got=%0d exp=1", drop_cnt); errs++; end
        glog.delete();
        push(0, 16'h0155);
        #1;
        vecs++; if (in_pop !== 4'b0001) begin $display("FAIL ar_grant got=%b exp=0001", in_pop); errs++; end
        tick();
        rst_n = 1'b0;
        #1;
        vecs++; if (in_pop !== 4'b0000) begin $display("FAIL ar_pop got=%b exp=0000", in_pop); errs++; end
        vecs++; if (out_pndng !== 4'b0000) begin $display("FAIL ar_pndng got=%b exp=0000", out_pndng); errs++; end
        vecs++; if (drop_cnt !== 16'h0) begin $display("FAIL ar_drop got=%h exp=0", drop_cnt); errs++; end
        vecs++; if (out_data !== 64'h0) begin $display("FAIL ar_data got=%h exp=0", out_data); errs++; end
        tick();
        clear_devs();
        rst_n = 1'b1;
        repeat (4) tick();
        vecs++; if (out_pndng !== 4'b0000) begin $display("FAIL ar_ghost got=%b exp=0000", out_pndng); errs++; end
        vecs++; if (drop_cnt !== 16'h0) begin $display("FAIL ar_post_drop got=%h exp=0", drop_cnt); errs++; end
        vecs++; if (glog.size() != 1) begin $display("FAIL ar_grants got=%0d exp=1", glog.size()); errs++; end
    endtask

    initial begin
        rst_n   = 1'b0;
        out_pop = '0;
        clear_devs();
        test_reset();
        test_unicast();
        test_broadcast();
        test_invalid();
        test_backpressure();
        test_round_robin();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
